// File: rtl/ps2_rx_ctrl.sv
// PS/2 keyboard receive controller: pin synchronisers, ps2_clk glitch filter, and frame FSM.
// Optional macro PS2_TIMEOUT_EN adds an inter-edge timeout that aborts stalled frames.
module ps2_rx_ctrl #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rx_en,
  output logic [7:0] dato,
  output logic       load,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic                  clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic [FILTER_LEN-1:0] filt_q;
  logic                  fclk_q;
  logic                  fall;
  logic                  to_hit;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] dato_q, dato_d;
  logic       par_q, par_d;
  logic       load_q, load_d;
  logic       err_q, err_d;

  // Presetting to 1 models an idle-high line so reset release never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      filt_q   <= '1;
      fclk_q   <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
      filt_q   <= {filt_q[FILTER_LEN-2:0], clk_s2_q};
      if (&filt_q)
        fclk_q <= 1'b1;
      else if (~|filt_q)
        fclk_q <= 1'b0;
    end
  end

  assign fall = fclk_q & ~|filt_q;

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      to_q <= '0;
    else if (fall || state_q == IDLE)
      to_q <= '0;
    else if (!to_hit)
      to_q <= to_q + 1'b1;
  end

  assign to_hit = (to_q == TW'(TIMEOUT_CYC - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      sh_q    <= 8'h00;
      dato_q  <= 8'h00;
      par_q   <= 1'b0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      dato_q  <= dato_d;
      par_q   <= par_d;
      load_q  <= load_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    dato_d  = dato_q;
    par_d   = par_q;
    load_d  = 1'b0;
    err_d   = 1'b0;
    if (fall) begin
      case (state_q)
        IDLE: begin
          if (rx_en && !dat_s2_q) begin
            state_d = DATA;
            cnt_d   = 3'd0;
          end
        end
        DATA: begin
          sh_d  = {dat_s2_q, sh_q[7:1]};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7)
            state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_s2_q;
          state_d = STOP;
        end
        default: begin
          // Odd parity over data plus parity bit, and a high stop bit.
          if ((^sh_q ^ par_q) && dat_s2_q) begin
            dato_d = sh_q;
            load_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
      endcase
    end else if (to_hit && state_q != IDLE) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
  end

  assign dato      = dato_q;
  assign load      = load_q;
  assign frame_err = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Testbench for ps2_rx_ctrl: table vectors, corner-case sequences and random frames
// against a frame-level reference model. Timeout test runs when PS2_TIMEOUT_EN is defined.
module tb_ps2_rx_ctrl;
  localparam int FL   = 4;
  localparam int TO   = 300;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rx_en = 1'b1;
  logic [7:0] dato;
  logic       load, frame_err, busy;

  ps2_rx_ctrl #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rx_en(rx_en),
    .dato(dato), .load(load), .frame_err(frame_err), .busy(busy)
  );

  always #10 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  int n_load = 0, n_err = 0, load_cyc = 0, err_cyc = 0, t_fall = 0;
  logic [7:0] prev_dato = 8'h00;
  logic prev_busy = 1'b0, busy_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_seen = 1'b1;
      if (load) begin
        n_load++;
        load_cyc = cyc;
        checks++;
        if (frame_err || busy || !prev_busy) begin
          failures++;
          $display("FAIL load_excl got err=%0b busy=%0b prev_busy=%0b exp 0,0,1", frame_err, busy, prev_busy);
        end
      end
      if (frame_err) begin
        n_err++;
        err_cyc = cyc;
      end
      if (dato !== prev_dato) begin
        checks++;
        if (!load) begin
          failures++;
          $display("FAIL dato_stable got=%0h exp=%0h (no load)", dato, prev_dato);
        end
      end
    end
    prev_dato = dato;
    prev_busy = busy;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic glitch();
    ps2_clk = 1'b0;
    repeat (FL - 2) @(posedge clk);
    #2 ps2_clk = 1'b1;
  endtask

  // Sends the first nbits of a frame; optional clock glitch / rx_en drop after a given bit index.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop,
                            input int nbits, input int glitch_after, input int drop_en_after);
    logic [10:0] bits;
    bits = {stop, p, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #2 ps2_data = bits[i];
      repeat (HALF) @(posedge clk);
      #2 ps2_clk = 1'b0;
      t_fall = cyc;
      repeat (HALF) @(posedge clk);
      #2 ps2_clk = 1'b1;
      if (i == drop_en_after) rx_en = 1'b0;
      if (i == glitch_after) begin
        repeat (HALF / 2) @(posedge clk);
        #2 glitch();
      end
    end
    repeat (HALF) @(posedge clk);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       stop;
    logic       en;
    logic       exp_load;
    logic       exp_err;
    logic [7:0] exp_dato;
  } vec_t;

  vec_t vecs[5];
  int l0, e0;
  logic [7:0] exp_dato;

  initial begin
    #4000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h1C};
    vecs[1] = '{8'hF0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h1C};
    vecs[2] = '{8'h45, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h1C};
    vecs[3] = '{8'h45, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h45};
    vecs[4] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h45};

    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    repeat (FL + 4) @(posedge clk);
    #5;
    check("reset_dato", dato, 8'h00);
    check("reset_load", load, 1'b0);
    check("reset_err", frame_err, 1'b0);
    check("reset_busy", busy, 1'b0);

    foreach (vecs[k]) begin
      l0 = n_load; e0 = n_err; busy_seen = 1'b0;
      rx_en = vecs[k].en;
      send_frame(vecs[k].d, vecs[k].p, vecs[k].stop, 11, -1, -1);
      repeat (FL + 10) @(posedge clk);
      check($sformatf("vec%0d_loads", k), n_load - l0, vecs[k].exp_load);
      check($sformatf("vec%0d_errs", k), n_err - e0, vecs[k].exp_err);
      check($sformatf("vec%0d_dato", k), dato, vecs[k].exp_dato);
      if (vecs[k].exp_load) check($sformatf("vec%0d_latency", k), load_cyc - t_fall, FL + 3);
      if (vecs[k].exp_err) check($sformatf("vec%0d_err_latency", k), err_cyc - t_fall, FL + 3);
      if (!vecs[k].en) check("rx_off_busy", busy_seen, 1'b0);
    end
    rx_en = 1'b1;

    // Glitches in IDLE (data low) and mid-DATA must not consume a bit.
    l0 = n_load; e0 = n_err;
    @(posedge clk); #2 ps2_data = 1'b0;
    repeat (4) @(posedge clk);
    #2 glitch();
    repeat (FL + 10) @(posedge clk);
    #5 check("glitch_idle_busy", busy, 1'b0);
    send_frame(8'h29, 1'b0, 1'b1, 11, 3, -1);
    repeat (FL + 10) @(posedge clk);
    check("glitch_loads", n_load - l0, 1);
    check("glitch_errs", n_err - e0, 0);
    check("glitch_dato", dato, 8'h29);

    // rx_en dropped mid-frame: frame still completes.
    l0 = n_load;
    send_frame(8'h5A, 1'b1, 1'b1, 11, -1, 4);
    repeat (FL + 10) @(posedge clk);
    check("en_drop_loads", n_load - l0, 1);
    check("en_drop_dato", dato, 8'h5A);
    rx_en = 1'b1;

    // Reset after data bit 4 discards the partial frame.
    send_frame(8'h33, 1'b1, 1'b1, 5, -1, -1);
    #5 check("pre_rst_busy", busy, 1'b1);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("rst_dato", dato, 8'h00);
    check("rst_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0; ps2_data = 1'b1;
    repeat (FL + 4) @(posedge clk);
    l0 = n_load;
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1, -1);
    repeat (FL + 10) @(posedge clk);
    check("post_rst_loads", n_load - l0, 1);
    check("post_rst_dato", dato, 8'h1C);

`ifdef PS2_TIMEOUT_EN
    l0 = n_load; e0 = n_err;
    send_frame(8'h77, 1'b1, 1'b1, 5, -1, -1);
    for (int w = 0; w < 3 * TO && n_err == e0; w++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("timeout_errs", n_err - e0, 1);
    check("timeout_loads", n_load - l0, 0);
    check("timeout_latency", err_cyc - t_fall, FL + 3 + TO);
    #5 check("timeout_busy", busy, 1'b0);
    check("timeout_dato", dato, 8'h1C);
    @(posedge clk); #2 ps2_data = 1'b1;
`endif

    // Random frames against a frame-level model.
    exp_dato = dato;
    for (int r = 0; r < 20; r++) begin
      logic [7:0] d;
      logic p, stop, en, ok;
      d    = 8'($urandom);
      p    = ($urandom_range(3) == 0) ? (^d) : ~(^d);
      stop = ($urandom_range(7) != 0);
      en   = ($urandom_range(4) != 0);
      ok   = ((^d ^ p) == 1'b1) && stop;
      l0 = n_load; e0 = n_err;
      rx_en = en;
      send_frame(d, p, stop, 11, -1, -1);
      repeat (FL + 10) @(posedge clk);
      if (en && ok) exp_dato = d;
      check($sformatf("rand%0d_loads", r), n_load - l0, (en && ok) ? 1 : 0);
      check($sformatf("rand%0d_errs", r), n_err - e0, (en && !ok) ? 1 : 0);
      check($sformatf("rand%0d_dato", r), dato, exp_dato);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
